// File: rtl/io_poll_master.sv
// io_poll_master
//
// Bus initiator for the processor-side port of the I/O bridge. It stands in for the CPU
// in the FPGA test top. Each poll reads the DIP-switch data register and writes the value
// it read to the LED data register. Polls are started by `en` (free-running) or by a
// one-cycle `trig`.
//
// Poll sequence: StIdle -> StRaddr -> StRcap -> StWrite -> StWait -> (StRaddr | StIdle)
//   StRaddr  drive the switch address
//   StRcap   hold the address; PrRD is captured on the edge leaving this state
//   StWrite  drive the LED address and the captured data with Wr=1 for one cycle
//   StWait   count POLL_DIV cycles. A trig here cuts the wait short.
//
// All bus outputs are registered. They are computed from the next state, so each output
// lines up with the state it belongs to.
//
// Parameters:
//   SWITCH_ADDR  bridge address of the switch data register
//   LED_ADDR     bridge address of the LED data register
//   POLL_DIV     number of StWait cycles between polls (1..65535)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   polling enable
//   trig       in   one-cycle request for an immediate poll
//   PrRD       in   [31:0] read data from the bridge (combinational from PrAddr)
//   PrAddr     out  [31:0] bus address
//   PrWD       out  [31:0] bus write data
//   Wr         out  write strobe, one cycle per write
//   BE         out  [3:0] byte enables
//   busy       out  high in StRaddr / StRcap / StWrite
//   poll_done  out  one-cycle pulse in the cycle after a write
//   last_val   out  [31:0] last value written to the LEDs
//
// Build option:
//   IO_POLL_CHANGE_ONLY_EN  when defined, a poll skips the LED write if the switch value
//                           equals last_val. The first poll after reset always writes.

module io_poll_master #(
  parameter logic [31:0] SWITCH_ADDR = 32'h0000_7F2C,
  parameter logic [31:0] LED_ADDR    = 32'h0000_7F34,
  parameter int unsigned POLL_DIV    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        trig,
  input  logic [31:0] PrRD,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        Wr,
  output logic [3:0]  BE,
  output logic        busy,
  output logic        poll_done,
  output logic [31:0] last_val
);

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRcap,
    StWrite,
    StWait
  } state_e;

  localparam logic [15:0] WaitLoad = 16'(POLL_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] capture_q, capture_d;
  logic [31:0] praddr_q, praddr_d;
  logic [31:0] prwd_q, prwd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic        busy_q, busy_d;
  logic        poll_done_q, poll_done_d;
  logic [31:0] last_val_q, last_val_d;

`ifdef IO_POLL_CHANGE_ONLY_EN
  // Set after the first write since reset. Until then, the comparison against last_val
  // (which reset to 0) must not suppress a write.
  logic wrote_once_q;
  logic skip_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrote_once_q <= 1'b0;
    end else if (state_q == StWrite) begin
      wrote_once_q <= 1'b1;
    end
  end

  assign skip_write = wrote_once_q && (PrRD == last_val_q);
`endif

  // ---------------------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      capture_q   <= '0;
      praddr_q    <= '0;
      prwd_q      <= '0;
      wr_q        <= 1'b0;
      be_q        <= 4'b0000;
      busy_q      <= 1'b0;
      poll_done_q <= 1'b0;
      last_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      capture_q   <= capture_d;
      praddr_q    <= praddr_d;
      prwd_q      <= prwd_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      busy_q      <= busy_d;
      poll_done_q <= poll_done_d;
      last_val_q  <= last_val_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en || trig) begin
          state_d = StRaddr;
        end
      end
      StRaddr: begin
        state_d = StRcap;
      end
      StRcap: begin
`ifdef IO_POLL_CHANGE_ONLY_EN
        if (skip_write) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end else begin
          state_d = StWrite;
        end
`else
        state_d = StWrite;
`endif
      end
      StWrite: begin
        state_d = StWait;
        cnt_d   = WaitLoad;
      end
      StWait: begin
        if (trig) begin
          state_d = StRaddr;
        end else if (cnt_q == 16'd0) begin
          // en is checked only here, so a poll already in flight always finishes.
          state_d = en ? StRaddr : StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Output logic. Registered outputs are decoded from the state being entered.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    capture_d   = (state_q == StRcap) ? PrRD : capture_q;
    praddr_d    = praddr_q;
    prwd_d      = prwd_q;
    wr_d        = 1'b0;
    be_d        = 4'b0000;
    busy_d      = 1'b0;
    poll_done_d = (state_q == StWrite);
    last_val_d  = (state_q == StWrite) ? capture_q : last_val_q;
    unique case (state_d)
      StRaddr: begin
        praddr_d = SWITCH_ADDR;
        be_d     = 4'b1111;
        busy_d   = 1'b1;
      end
      StRcap: begin
        be_d   = 4'b1111;
        busy_d = 1'b1;
      end
      StWrite: begin
        // StWrite is entered only from StRcap, so capture_d holds this poll's read data.
        praddr_d = LED_ADDR;
        prwd_d   = capture_d;
        wr_d     = 1'b1;
        be_d     = 4'b1111;
        busy_d   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PrAddr    = praddr_q;
  assign PrWD      = prwd_q;
  assign Wr        = wr_q;
  assign BE        = be_q;
  assign busy      = busy_q;
  assign poll_done = poll_done_q;
  assign last_val  = last_val_q;

`ifndef SYNTHESIS
  a_wr_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    Wr |-> (state_q == StWrite));
  a_wr_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    Wr |=> !Wr);
  a_done_after_write: assert property (@(posedge clk) disable iff (!rst_n)
    poll_done |-> (state_q == StWait));
`endif

endmodule

// File: tb/tb_io_poll_master.sv
module tb_io_poll_master;

  localparam logic [31:0] SwAddr  = 32'h0000_7F2C;
  localparam logic [31:0] LedAddr = 32'h0000_7F34;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        trig;
  logic [31:0] PrRD;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        Wr;
  logic [3:0]  BE;
  logic        busy;
  logic        poll_done;
  logic [31:0] last_val;

  logic [31:0] sw;
  int          n_vec;
  int          n_err;
  int          cyc;
  int          last_wr;
  int          t0;
  int          nwr;

  io_poll_master #(
    .SWITCH_ADDR(SwAddr),
    .LED_ADDR   (LedAddr),
    .POLL_DIV   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .trig     (trig),
    .PrRD     (PrRD),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .Wr       (Wr),
    .BE       (BE),
    .busy     (busy),
    .poll_done(poll_done),
    .last_val (last_val)
  );

  // Bridge model: only the switch register returns the switch value.
  assign PrRD = (PrAddr == SwAddr) ? sw : 32'hDEAD_BEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (Wr !== 1'b1 && n < budget);
    if (Wr !== 1'b1) check({tag, "_timeout"}, {31'b0, Wr}, 32'd1);
  endtask

  task automatic count_wr(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (Wr === 1'b1) cnt++;
    end
  endtask

  task automatic do_reset(input logic en_v, input logic [31:0] sw_v);
    rst_n = 1'b0;
    en    = en_v;
    trig  = 1'b0;
    sw    = sw_v;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;

    // Reset values, then the first poll with en held high.
    rst_n = 1'b0;
    en    = 1'b1;
    trig  = 1'b0;
    sw    = 32'h1234_5678;
    tick(2);
    check("rst_praddr", PrAddr, 32'h0);
    check("rst_prwd", PrWD, 32'h0);
    check("rst_wr", {31'b0, Wr}, 32'd0);
    check("rst_be", {28'b0, BE}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, poll_done}, 32'd0);
    check("rst_lastval", last_val, 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("t1_raddr_busy", {31'b0, busy}, 32'd1);
    check("t1_raddr_addr", PrAddr, SwAddr);
    check("t1_raddr_be", {28'b0, BE}, 32'hF);
    check("t1_raddr_wr", {31'b0, Wr}, 32'd0);
    tick(1);
    check("t1_rcap_addr", PrAddr, SwAddr);
    check("t1_rcap_wr", {31'b0, Wr}, 32'd0);
    tick(1);
    check("t1_wr", {31'b0, Wr}, 32'd1);
    check("t1_wr_addr", PrAddr, LedAddr);
    check("t1_wr_data", PrWD, 32'h1234_5678);
    check("t1_wr_be", {28'b0, BE}, 32'hF);
    last_wr = cyc;
    tick(1);
    check("t1_wr_drop", {31'b0, Wr}, 32'd0);
    check("t1_done", {31'b0, poll_done}, 32'd1);
    check("t1_lastval", last_val, 32'h1234_5678);
    check("t1_wait_be", {28'b0, BE}, 32'd0);
    check("t1_wait_busy", {31'b0, busy}, 32'd0);
    tick(1);
    check("t1_done_pulse", {31'b0, poll_done}, 32'd0);

    // Steady-state period: 16 wait cycles + RADDR + RCAP + WRITE.
    sw = 32'hCAFE_0001;
    wait_wr("t2a", 40);
    check("t2a_period", cyc - last_wr, 32'd19);
    check("t2a_data", PrWD, 32'hCAFE_0001);
    last_wr = cyc;
    sw = 32'h0BAD_F00D;
    wait_wr("t2b", 40);
    check("t2b_period", cyc - last_wr, 32'd19);
    check("t2b_data", PrWD, 32'h0BAD_F00D);
    last_wr = cyc;
    // Switch changes during the RCAP cycle: that value is the one captured.
    tick(18);
    check("t2c_rcap_busy", {31'b0, busy}, 32'd1);
    check("t2c_rcap_addr", PrAddr, SwAddr);
    sw = 32'h7777_AAAA;
    tick(1);
    check("t2c_wr", {31'b0, Wr}, 32'd1);
    check("t2c_period", cyc - last_wr, 32'd19);
    check("t2c_data", PrWD, 32'h7777_AAAA);

    // en=0: trig from idle, then trig in wait cycle 5.
    do_reset(1'b0, 32'h0000_00C3);
    tick(5);
    check("t3_idle_busy", {31'b0, busy}, 32'd0);
    check("t3_idle_addr", PrAddr, 32'h0);
    trig = 1'b1;
    t0   = cyc;
    tick(1);
    trig = 1'b0;
    check("t3_trig_busy", {31'b0, busy}, 32'd1);
    wait_wr("t3a", 10);
    check("t3a_latency", cyc - t0, 32'd3);
    check("t3a_data", PrWD, 32'h0000_00C3);
    tick(5);
    trig = 1'b1;
    t0   = cyc;
    tick(1);
    trig = 1'b0;
    sw   = 32'h0000_003C;
    wait_wr("t3b", 10);
    check("t3b_latency", cyc - t0, 32'd3);
    check("t3b_data", PrWD, 32'h0000_003C);
    count_wr(200, nwr);
    check("t3_no_more_wr", nwr, 32'd0);
    check("t3_idle_end", {31'b0, busy}, 32'd0);

    // en dropped in RCAP (and a trig there, which must be ignored).
    do_reset(1'b1, 32'h0F0F_0F0F);
    tick(2);
    check("t4_rcap_busy", {31'b0, busy}, 32'd1);
    en   = 1'b0;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    check("t4_wr", {31'b0, Wr}, 32'd1);
    check("t4_data", PrWD, 32'h0F0F_0F0F);
    tick(1);
    check("t4_done", {31'b0, poll_done}, 32'd1);
    count_wr(200, nwr);
    check("t4_no_more_wr", nwr, 32'd0);
    check("t4_idle", {31'b0, busy}, 32'd0);
    check("t4_lastval", last_val, 32'h0F0F_0F0F);

    // Reset asserted during a write.
    do_reset(1'b1, 32'h1111_2222);
    wait_wr("t5a", 5);
    check("t5a_data", PrWD, 32'h1111_2222);
    sw = 32'h3333_4444;
    wait_wr("t5b", 25);
    check("t5b_data", PrWD, 32'h3333_4444);
    check("t5b_lastval", last_val, 32'h1111_2222);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_wr", {31'b0, Wr}, 32'd0);
    check("t5_rst_addr", PrAddr, 32'h0);
    check("t5_rst_lastval", last_val, 32'h0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    sw    = 32'h5555_6666;
    t0    = cyc;
    wait_wr("t5c", 10);
    check("t5c_latency", cyc - t0, 32'd3);
    check("t5c_data", PrWD, 32'h5555_6666);
    check("t5c_lastval", last_val, 32'h0);

`ifdef IO_POLL_CHANGE_ONLY_EN
    // Change-only build: constant switch gives a single write.
    do_reset(1'b1, 32'h0000_00A5);
    count_wr(100, nwr);
    check("t6_const_wr", nwr, 32'd1);
    check("t6_lastval_a5", last_val, 32'h0000_00A5);
    sw = 32'h0000_005A;
    count_wr(100, nwr);
    check("t6_change_wr", nwr, 32'd1);
    check("t6_data", PrWD, 32'h0000_005A);
    check("t6_lastval_5a", last_val, 32'h0000_005A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
